// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Shared MIPS encoding constants for the instruction encoder
//               and the controller decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

    localparam logic [3:0] KIND_NOP  = 4'd0;
    localparam logic [3:0] KIND_ADDU = 4'd1;
    localparam logic [3:0] KIND_SUBU = 4'd2;
    localparam logic [3:0] KIND_ORI  = 4'd3;
    localparam logic [3:0] KIND_LW   = 4'd4;
    localparam logic [3:0] KIND_SW   = 4'd5;
    localparam logic [3:0] KIND_BEQ  = 4'd6;
    localparam logic [3:0] KIND_LUI  = 4'd7;
    localparam logic [3:0] KIND_J    = 4'd8;
    localparam logic [3:0] KIND_JAL  = 4'd9;
    localparam logic [3:0] KIND_JR   = 4'd10;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage : instr_pkg
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational MIPS word assembler from mnemonic kind + fields.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        is_branch,
    output logic        illegal
);

    always_comb begin
        word      = NOP_WORD;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (kind)
            KIND_NOP:  word = NOP_WORD;
            KIND_ADDU: word = {OP_SPECIAL, rs, rt, rd, 5'h00, FUNCT_ADDU};
            KIND_SUBU: word = {OP_SPECIAL, rs, rt, rd, 5'h00, FUNCT_SUBU};
            KIND_ORI:  word = {OP_ORI, rs, rt, imm[15:0]};
            KIND_LW:   word = {OP_LW,  rs, rt, imm[15:0]};
            KIND_SW:   word = {OP_SW,  rs, rt, imm[15:0]};
            KIND_LUI:  word = {OP_LUI, 5'h00, rt, imm[15:0]};
            KIND_BEQ: begin
                word      = {OP_BEQ, rs, rt, imm[15:0]};
                is_branch = 1'b1;
            end
            KIND_J: begin
                word      = {OP_J, imm};
                is_branch = 1'b1;
            end
            KIND_JAL: begin
                word      = {OP_JAL, imm};
                is_branch = 1'b1;
            end
            KIND_JR: begin
                word      = {OP_SPECIAL, rs, 15'h0000, FUNCT_JR};
                is_branch = 1'b1;
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule : instr_pack
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes MIPS instructions into a FIFO and streams them out
//               with sequential PC addresses, optionally padding delay slots.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_pkg::*;
#(
    parameter int          DEPTH          = 8,
    parameter logic [31:0] PC_BASE        = 32'h0000_3000,
    parameter bit          PAD_DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [25:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [7:0]  illegal_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   w_word;
    logic          w_is_branch;
    logic          w_illegal;
    logic          w_accept;
    logic          w_pop;
    logic [1:0]    w_pushes;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   out_addr_q, out_addr_d;
    logic          err_q, err_d;
    logic [7:0]    illegal_cnt_q, illegal_cnt_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];

    instr_pack u_pack (
        .kind      (in_kind),
        .rs        (in_rs),
        .rt        (in_rt),
        .rd        (in_rd),
        .imm       (in_imm),
        .word      (w_word),
        .is_branch (w_is_branch),
        .illegal   (w_illegal)
    );

    // Space is judged on registered occupancy only, leaving room for a pair.
    generate
        if (PAD_DELAY_SLOT) begin : g_pad
            assign in_ready = (count_q <= CW'(DEPTH - 2));
        end else begin : g_nopad
            assign in_ready = (count_q < CW'(DEPTH));
        end
    endgenerate

    assign out_valid   = (count_q != '0);
    assign out_instr   = mem_q[rd_ptr_q];
    assign out_addr    = out_addr_q;
    assign err_illegal = err_q;
    assign illegal_cnt = illegal_cnt_q;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_pushes = 2'd0;
        if (w_accept && !w_illegal) begin
            w_pushes = (PAD_DELAY_SLOT && w_is_branch) ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (w_pushes != 2'd0) begin
            mem_d[wr_ptr_q] = w_word;
        end
        if (w_pushes == 2'd2) begin
            mem_d[wr_ptr_q + AW'(1)] = NOP_WORD;
        end
        wr_ptr_d      = wr_ptr_q + AW'(w_pushes);
        rd_ptr_d      = rd_ptr_q + AW'(w_pop);
        count_d       = count_q + CW'(w_pushes) - CW'(w_pop);
        out_addr_d    = w_pop ? (out_addr_q + 32'd4) : out_addr_q;
        err_d         = w_accept & w_illegal;
        illegal_cnt_d = illegal_cnt_q;
        if (w_accept && w_illegal && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_addr_q    <= PC_BASE;
            err_q         <= 1'b0;
            illegal_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_addr_q    <= out_addr_d;
            err_q         <= err_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_valid0;
    logic        in_ready, in_ready0;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [25:0] in_imm;
    logic        out_valid, out_valid0;
    logic        out_ready, out_ready0;
    logic [31:0] out_instr, out_instr0;
    logic [31:0] out_addr, out_addr0;
    logic        err_illegal, err_illegal0;
    logic [7:0]  illegal_cnt, illegal_cnt0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(8), .PC_BASE(32'h0000_3000), .PAD_DELAY_SLOT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    instr_encoder #(.DEPTH(8), .PC_BASE(32'h0000_3000), .PAD_DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_instr(out_instr0), .out_addr(out_addr0),
        .err_illegal(err_illegal0), .illegal_cnt(illegal_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm);
        in_kind  = k;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send0(input logic [3:0] k, input logic [25:0] imm);
        in_kind   = k;
        in_rs     = 5'd0;
        in_rt     = 5'd1;
        in_rd     = 5'd0;
        in_imm    = imm;
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_instr,
                             input logic [31:0] exp_addr);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_addr"},  out_addr,  exp_addr);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int acc;
        reset = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b0; out_ready0 = 1'b0;
        in_kind = 4'd0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_addr", out_addr, 32'h0000_3000);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_err", {31'd0, err_illegal}, 32'd0);
        check("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic R/I-type words and sequential addresses
        send(4'd1, 5'd1, 5'd2, 5'd3, 26'd0);
        check("lat1_valid", {31'd0, out_valid}, 32'd1);
        send(4'd3, 5'd0, 5'd1, 5'd0, 26'h1234);
        pop_check("addu", 32'h0022_1821, 32'h0000_3000);
        pop_check("ori",  32'h3401_1234, 32'h0000_3004);

        // Loads, lui, jal/jr with padded delay slots
        send(4'd4, 5'd29, 5'd8, 5'd0, 26'd4);
        send(4'd7, 5'd0, 5'd5, 5'd0, 26'hABCD);
        send(4'd9, 5'd0, 5'd0, 5'd0, 26'h0000C03);
        send(4'd10, 5'd31, 5'd0, 5'd0, 26'd0);
        pop_check("lw",      32'h8FA8_0004, 32'h0000_3008);
        pop_check("lui",     32'h3C05_ABCD, 32'h0000_300C);
        pop_check("jal",     32'h0C00_0C03, 32'h0000_3010);
        pop_check("jal_nop", 32'h0000_0000, 32'h0000_3014);
        pop_check("jr",      32'h03E0_0008, 32'h0000_3018);
        pop_check("jr_nop",  32'h0000_0000, 32'h0000_301C);
        check("drained", {31'd0, out_valid}, 32'd0);

        // beq with delay slot from a fresh base
        do_reset();
        send(4'd6, 5'd1, 5'd2, 5'd0, 26'h000FFFF);
        pop_check("beq",     32'h1022_FFFF, 32'h0000_3000);
        pop_check("beq_nop", 32'h0000_0000, 32'h0000_3004);

        // Backpressure with padding: stops at count 7
        do_reset();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready) break;
            send(4'd3, 5'd0, 5'd1, 5'd0, 26'(i));
            acc++;
        end
        check("pad1_accepted", 32'(acc), 32'd7);
        check("pad1_head", out_instr, 32'h3401_0000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pad1_ready_after_pop", {31'd0, in_ready}, 32'd1);
        for (int i = 1; i < 7; i++) begin
            pop_check("pad1_drain", 32'h3401_0000 | 32'(i), 32'h0000_3000 + 32'(4 * i));
        end
        check("pad1_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure without padding: stops at count 8
        do_reset();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready0) break;
            send0(4'd3, 26'(i));
            acc++;
        end
        check("pad0_accepted", 32'(acc), 32'd8);
        check("pad0_head", out_instr0, 32'h3401_0000);
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        check("pad0_ready_after_pop", {31'd0, in_ready0}, 32'd1);
        check("pad0_next", out_instr0, 32'h3401_0001);
        check("pad0_addr", out_addr0, 32'h0000_3004);

        // Illegal kinds and counter saturation
        do_reset();
        send(4'd12, 5'd0, 5'd0, 5'd0, 26'd0);
        check("ill_err", {31'd0, err_illegal}, 32'd1);
        check("ill_cnt1", {24'd0, illegal_cnt}, 32'd1);
        check("ill_no_word", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("ill_err_pulse", {31'd0, err_illegal}, 32'd0);
        in_kind  = 4'd15;
        in_valid = 1'b1;
        repeat (256) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ill_cnt_sat", {24'd0, illegal_cnt}, 32'd255);
        check("ill_sat_no_word", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream discards buffered words
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(4'd2, 5'd4, 5'd5, 5'd6, 26'd0);
        end
        check("mid_buffered", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_addr", out_addr, 32'h0000_3000);
        @(posedge clk); #1;
        reset = 1'b0;
        send(4'd1, 5'd1, 5'd2, 5'd3, 26'd0);
        pop_check("post_rst", 32'h0022_1821, 32'h0000_3000);
        check("post_rst_empty", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instr_encoder
`default_nettype wire
